mips_regfile_param: RTL and testbench
=====================================

MIPS_REGFILE_PARAM -- requirements
Module: mips_regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports read_reg_1, read_reg_2  input  ADDR_W  read addresses.
REQ-007 SHALL have ports read_data_1, read_data_2  output  DATA_W  read data.
REQ-008 SHALL have port write_reg  input  ADDR_W  write address.
REQ-009 SHALL have port write_data  input  DATA_W  write data.
REQ-010 SHALL have port write_be  input  DATA_W/8  byte enables; bit i gates byte i.
REQ-011 SHALL have port signal_reg_write  input  1  write strobe.
REQ-012 SHALL have port init_done  output  1  high once the clear sequence has completed.

Function
REQ-013 SHALL implement two states, CLEAR and READY, and enter CLEAR on reset.
REQ-014 In CLEAR, SHALL write all-zero to register clr_cnt each cycle, with clr_cnt starting at 0 and incrementing by 1.
REQ-015 SHALL move CLEAR->READY on the cycle it clears DEPTH-1, so CLEAR lasts exactly DEPTH cycles; clr_cnt wraps to 0.
REQ-016 SHALL hold init_done=0 in CLEAR and init_done=1 in READY; READY is left only by reset.
REQ-017 In CLEAR, SHALL ignore signal_reg_write and drive read_data_1/2 = 0.
REQ-018 In READY with signal_reg_write=1, SHALL update each byte i of registers[write_reg] where write_be[i]=1 and leave every other byte unchanged.
REQ-019 With ZERO_REG=1, SHALL drop writes to address 0; read_data for address 0 is 0 regardless of bypass.
REQ-020 Reads SHALL be combinational, with zero added cycle latency.
REQ-021 In READY, when signal_reg_write=1 and read_reg_n==write_reg, SHALL drive read_data_n = byte-merge of write_data into the stored value (write-through bypass).
REQ-022 Bypass SHALL apply independently to both read ports; both may hit the same write address at once.
REQ-023 write_be=0 with signal_reg_write=1 SHALL change no state, and bypass returns the stored value.
REQ-024 The ZERO_REG=0 build SHALL treat address 0 as an ordinary register.

Reset
REQ-025 rst=1 at a rising edge SHALL force state=CLEAR, clr_cnt=0 and init_done=0 from the next cycle.
REQ-026 Reset asserted mid-CLEAR SHALL restart the sweep from address 0.
REQ-027 Reset asserted in READY SHALL restart the full DEPTH-cycle clear.
REQ-028 The register array SHALL have no reset term; it is zeroed only by the CLEAR sweep.
REQ-029 During reset and CLEAR, read_data_1/2 SHALL be 0 and init_done SHALL be 0.

Structure
REQ-030 Shared package mips_pkg SHALL hold the state typedef (CLEAR, READY) and the default DATA_W and ADDR_W constants.
REQ-031 Byte-enable merging SHALL live in one combinational sub-module, mips_byte_merge (old, new, be -> merged), instantiated for the write path and for each bypass path.
REQ-032 Target size: 120-400 RTL lines, with no vendor primitives.

Verification
REQ-033 Reset, then count cycles -> init_done rises exactly 8 cycles after rst deasserts (ADDR_W=3); every read returns 0.
REQ-034 After init, write reg3=0xDEADBEEF with be=0xF, then write reg3=0x11223344 with be=0x3 -> reg3 reads 0xDEAD3344.
REQ-035 With read_reg_1=read_reg_2=5 and a same-cycle write of 0xCAFEF00D, be=0xF -> both ports show 0xCAFEF00D that cycle, and it persists after.
REQ-036 Write reg0=0xFFFFFFFF with ZERO_REG=1 -> read reg0=0, including in the same cycle; with ZERO_REG=0 -> reads 0xFFFFFFFF next cycle.
REQ-037 Write reg7=0x12345678, pulse rst at CLEAR cycle 4, then again in READY -> each pulse restarts 8 clear cycles, and reg7 reads 0 afterward.
REQ-038 Assert signal_reg_write during CLEAR with write_reg=2, data=0xAAAA5555 -> reg2 reads 0 after init_done.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared state type and default widths for the MIPS register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 3;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/mips_byte_merge.sv
// ============================================================================
// Module  : mips_byte_merge
// Purpose : Combinational byte-enable merge of new data into an old word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   new_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   merged_o
);

  localparam int BE_W = DATA_W / 8;

  generate
    for (genvar i = 0; i < BE_W; i++) begin : g_byte
      assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
    end
  endgenerate

endmodule : mips_byte_merge

`default_nettype wire

// File: rtl/mips_regfile_param.sv
// ============================================================================
// Module  : mips_regfile_param
// Purpose : Parameterised register file with byte enables, write-through
//           bypass and a post-reset clear sweep over every entry.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_regfile_param
  import mips_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int ADDR_W   = MIPS_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   read_reg_1,
  input  logic [ADDR_W-1:0]   read_reg_2,
  output logic [DATA_W-1:0]   read_data_1,
  output logic [DATA_W-1:0]   read_data_2,
  input  logic [ADDR_W-1:0]   write_reg,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] write_be,
  input  logic                signal_reg_write,
  output logic                init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  logic                ready;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd1_stored, rd2_stored;
  logic [DATA_W-1:0]   rd1_merged, rd2_merged;
  logic                rd1_hit, rd2_hit;
  logic                rd1_zero, rd2_zero;

  // ---------------- state machine ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // A reset cycle is treated as not-ready even if the state is still READY.
  assign ready     = (state_q == READY) && !rst;
  assign init_done = ready;

  // ---------------- write path ----------------
  mips_byte_merge #(.DATA_W(DATA_W)) u_wr_merge (
    .old_i    (regs_q[write_reg]),
    .new_i    (write_data),
    .be_i     (write_be),
    .merged_o (wr_merged)
  );

  assign wr_en = ready && signal_reg_write &&
                 !((ZERO_REG != 0) && (write_reg == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        regs_q[clr_cnt_q] <= '0;
      end else if (wr_en) begin
        regs_q[write_reg] <= wr_merged;
      end
    end
  end

  // ---------------- read ports with write-through bypass ----------------
  assign rd1_stored = regs_q[read_reg_1];
  assign rd2_stored = regs_q[read_reg_2];

  mips_byte_merge #(.DATA_W(DATA_W)) u_byp1_merge (
    .old_i    (rd1_stored),
    .new_i    (write_data),
    .be_i     (write_be),
    .merged_o (rd1_merged)
  );

  mips_byte_merge #(.DATA_W(DATA_W)) u_byp2_merge (
    .old_i    (rd2_stored),
    .new_i    (write_data),
    .be_i     (write_be),
    .merged_o (rd2_merged)
  );

  assign rd1_hit  = signal_reg_write && (read_reg_1 == write_reg);
  assign rd2_hit  = signal_reg_write && (read_reg_2 == write_reg);
  assign rd1_zero = (ZERO_REG != 0) && (read_reg_1 == '0);
  assign rd2_zero = (ZERO_REG != 0) && (read_reg_2 == '0);

  always_comb begin
    read_data_1 = '0;
    read_data_2 = '0;
    if (ready && !rd1_zero) begin
      read_data_1 = rd1_hit ? rd1_merged : rd1_stored;
    end
    if (ready && !rd2_zero) begin
      read_data_2 = rd2_hit ? rd2_merged : rd2_stored;
    end
  end

endmodule : mips_regfile_param

`default_nettype wire

// File: tb/tb_mips_regfile_param.sv
// ============================================================================
// Module  : tb_mips_regfile_param
// Purpose : Self-checking bench for mips_regfile_param, ZERO_REG=1 and =0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  read_reg_1, read_reg_2, write_reg;
  logic [31:0] write_data;
  logic [3:0]  write_be;
  logic        signal_reg_write;

  logic [31:0] rd1_z1, rd2_z1, rd1_z0, rd2_z0;
  logic        init_z1, init_z0;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: contents per build (index = ZERO_REG value) and the
  // number of non-reset edges since the last reset edge (>= 8 means ready).
  logic [31:0] mem [2][8];
  int          since_rst = 0;

  always #5 clk = ~clk;

  mips_regfile_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) u_z1 (
    .clk(clk), .rst(rst),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(rd1_z1), .read_data_2(rd2_z1),
    .write_reg(write_reg), .write_data(write_data), .write_be(write_be),
    .signal_reg_write(signal_reg_write), .init_done(init_z1)
  );

  mips_regfile_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) u_z0 (
    .clk(clk), .rst(rst),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(rd1_z0), .read_data_2(rd2_z0),
    .write_reg(write_reg), .write_data(write_data), .write_be(write_be),
    .signal_reg_write(signal_reg_write), .init_done(init_z0)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input int zr, input logic [2:0] a);
    logic [31:0] v;
    if (rst || since_rst < 8) return 32'h0;
    if (zr == 1 && a == 3'd0) return 32'h0;
    v = mem[zr][a];
    if (signal_reg_write && a == write_reg) v = merge(v, write_data, write_be);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] wa,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [2:0] a1, input logic [2:0] a2);
    @(negedge clk);
    rst = r; signal_reg_write = w; write_reg = wa; write_data = d;
    write_be = b; read_reg_1 = a1; read_reg_2 = a2;
    #1;
  endtask

  task automatic finish_cycle();
    logic [31:0] m;
    logic        exp_init;
    exp_init = !rst && (since_rst >= 8);
    chk("rd1_z1", rd1_z1, exp_rd(1, read_reg_1));
    chk("rd2_z1", rd2_z1, exp_rd(1, read_reg_2));
    chk("rd1_z0", rd1_z0, exp_rd(0, read_reg_1));
    chk("rd2_z0", rd2_z0, exp_rd(0, read_reg_2));
    chk("init_z1", {31'h0, init_z1}, {31'h0, exp_init});
    chk("init_z0", {31'h0, init_z0}, {31'h0, exp_init});
    @(posedge clk);
    if (rst) begin
      since_rst = 0;
    end else if (since_rst < 8) begin
      mem[0][since_rst] = 32'h0;
      mem[1][since_rst] = 32'h0;
      since_rst++;
    end else if (signal_reg_write) begin
      m = merge(mem[0][write_reg], write_data, write_be);
      mem[0][write_reg] = m;
      if (write_reg != 3'd0) mem[1][write_reg] = merge(mem[1][write_reg], write_data, write_be);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [2:0] wa,
                      input logic [31:0] d, input logic [3:0] b,
                      input logic [2:0] a1, input logic [2:0] a2);
    drive(r, w, wa, d, b, a1, a2);
    finish_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic       r, w;
    logic [2:0] wa, a1, a2;

    // Reset, then count edges until init_done rises; all reads are zero.
    step(1, 0, 0, 0, 0, 0, 1);
    n = 0;
    while (n < 20) begin
      drive(0, 0, 0, 0, 0, 3'(n), 3'(n + 1));
      if (init_z1) break;
      finish_cycle();
      n++;
    end
    finish_cycle();
    chk("init_latency", 32'(n), 32'd8);

    // Byte-enable partial overwrite.
    step(0, 1, 3, 32'hDEADBEEF, 4'hF, 1, 2);
    step(0, 1, 3, 32'h11223344, 4'h3, 3, 3);
    drive(0, 0, 0, 0, 0, 3, 4);
    chk("be_merge", rd1_z1, 32'hDEAD3344);
    finish_cycle();

    // Dual-port same-cycle bypass, then persistence.
    drive(0, 1, 5, 32'hCAFEF00D, 4'hF, 5, 5);
    chk("byp_p1", rd1_z1, 32'hCAFEF00D);
    chk("byp_p2", rd2_z1, 32'hCAFEF00D);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 5, 5);
    chk("byp_persist", rd2_z1, 32'hCAFEF00D);
    finish_cycle();

    // Zero-enable write changes nothing.
    drive(0, 1, 5, 32'h0BADBAD0, 4'h0, 5, 6);
    chk("be0_bypass", rd1_z1, 32'hCAFEF00D);
    finish_cycle();

    // Register 0 behaviour for both builds.
    drive(0, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0);
    chk("r0_z1_same", rd1_z1, 32'h0);
    chk("r0_z0_byp", rd2_z0, 32'hFFFFFFFF);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("r0_z1_next", rd1_z1, 32'h0);
    chk("r0_z0_next", rd1_z0, 32'hFFFFFFFF);
    finish_cycle();

    // Reset mid-clear and again in READY; reg7 ends up zero.
    step(0, 1, 7, 32'h12345678, 4'hF, 7, 0);
    step(1, 0, 0, 0, 0, 7, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 7, 3'(i));
    step(1, 0, 0, 0, 0, 7, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 7, 3'(i));
    step(0, 1, 7, 32'h12345678, 4'hF, 7, 7);
    step(1, 0, 0, 0, 0, 7, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 7, 3'(i));
    drive(0, 0, 0, 0, 0, 7, 7);
    chk("r7_after_rst", rd1_z1, 32'h0);
    finish_cycle();

    // Writes during CLEAR are ignored.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2, 32'hAAAA5555, 4'hF, 2, 2);
    drive(0, 0, 0, 0, 0, 2, 2);
    chk("clr_write_ign", rd1_z1, 32'h0);
    chk("clr_write_ign0", rd2_z0, 32'h0);
    finish_cycle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      w  = ($urandom_range(0, 2) != 0);
      wa = 3'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      step(r, w, wa, $urandom, 4'($urandom_range(0, 15)), a1, a2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mips_regfile_param

`default_nettype wire
